// File: rtl/pmp_pkg.sv
// rtl/pmp_pkg.sv - shared PMP types, encodings and CSR addresses
// Contents: pmpcfg_t byte layout, A-field and csr_op encodings,
// CSR base addresses, and the read-modify-write operand helper.
package pmp_pkg;

    localparam int NUM_ENTRIES = 16;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        logic [1:0] a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    typedef enum logic [1:0] {
        PMP_OFF   = 2'b00,
        PMP_TOR   = 2'b01,
        PMP_NA4   = 2'b10,
        PMP_NAPOT = 2'b11
    } pmp_a_e;

    localparam logic [11:0] CSR_PMPCFG_BASE  = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR_BASE = 12'h3B0;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] wdata);
        case (op)
            CSR_OP_WRITE: csr_apply_op = wdata;
            CSR_OP_SET:   csr_apply_op = old_val | wdata;
            CSR_OP_CLEAR: csr_apply_op = old_val & ~wdata;
            default:      csr_apply_op = old_val;
        endcase
    endfunction

endpackage

// File: rtl/pmp_cfg_legalize.sv
// rtl/pmp_cfg_legalize.sv - per-byte lock and WARL filter for pmpcfg writes
// Ports: old_byte (stored value), new_byte (operation result),
//        commit_byte (value to store).
// Option PMP_WARL_EN: clear reserved bits and the R=0/W=1 combination.
module pmp_cfg_legalize
    import pmp_pkg::*;
(
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    output logic [7:0] commit_byte
);

    pmpcfg_t old_cfg;
    pmpcfg_t new_cfg;
    pmpcfg_t leg_cfg;

    assign old_cfg = pmpcfg_t'(old_byte);
    assign new_cfg = pmpcfg_t'(new_byte);

    always_comb begin
        leg_cfg = new_cfg;
`ifdef PMP_WARL_EN
        leg_cfg.rsvd = 2'b00;
        if (!new_cfg.r) begin
            leg_cfg.w = 1'b0;
        end
`endif
        // A locked byte is frozen until reset.
        commit_byte = old_cfg.l ? old_byte : 8'(leg_cfg);
    end

endmodule

// File: rtl/pmp_csr_file.sv
// rtl/pmp_csr_file.sv - M-mode pmpcfg0-3 / pmpaddr0-15 CSR storage
// Ports: clk, rst_n (async active-low); csr_we/csr_re/csr_op/csr_addr/
//        csr_wdata/prive_mode request; csr_rdata/csr_rvalid/csr_illegal
//        registered response; pmp_update change pulse; pmpcfgN_data and
//        pmpaddrN_data buses to the PMP checker.
// Option PMP_WARL_EN: legalize written config bytes.
module pmp_csr_file
    import pmp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_we,
    input  logic        csr_re,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [1:0]  prive_mode,
    output logic [31:0] csr_rdata,
    output logic        csr_rvalid,
    output logic        csr_illegal,
    output logic        pmp_update,
    output logic [31:0] pmpcfg0_data,
    output logic [31:0] pmpcfg1_data,
    output logic [31:0] pmpcfg2_data,
    output logic [31:0] pmpcfg3_data,
    output logic [31:0] pmpaddr0_data,
    output logic [31:0] pmpaddr1_data,
    output logic [31:0] pmpaddr2_data,
    output logic [31:0] pmpaddr3_data,
    output logic [31:0] pmpaddr4_data,
    output logic [31:0] pmpaddr5_data,
    output logic [31:0] pmpaddr6_data,
    output logic [31:0] pmpaddr7_data,
    output logic [31:0] pmpaddr8_data,
    output logic [31:0] pmpaddr9_data,
    output logic [31:0] pmpaddr10_data,
    output logic [31:0] pmpaddr11_data,
    output logic [31:0] pmpaddr12_data,
    output logic [31:0] pmpaddr13_data,
    output logic [31:0] pmpaddr14_data,
    output logic [31:0] pmpaddr15_data
);

    logic [31:0] cfg_q  [4];
    logic [31:0] addr_q [NUM_ENTRIES];

    pmpcfg_t entry_cfg [NUM_ENTRIES];
    logic    addr_locked [NUM_ENTRIES];

    // 0x3A0-0x3BF share address bits [11:5]; bit 4 selects pmpaddr.
    logic        in_range;
    logic        is_addr;
    logic        unimpl;
    logic        illegal;
    logic        do_write;
    logic [1:0]  cfg_idx;
    logic [3:0]  addr_idx;
    logic [31:0] old_word;
    logic [31:0] new_word;
    logic [31:0] cfg_commit;
    logic [31:0] addr_commit;
    logic [31:0] commit_word;

    assign in_range = (csr_addr[11:5] == CSR_PMPCFG_BASE[11:5]);
    assign is_addr  = csr_addr[4];
    assign unimpl   = !csr_addr[4] && (csr_addr[3:2] != 2'b00);
    assign illegal  = in_range && (csr_we || csr_re) &&
                      ((prive_mode != 2'b11) || unimpl);
    assign do_write = in_range && csr_we && !illegal &&
                      (csr_op != CSR_OP_NONE);
    assign cfg_idx  = csr_addr[1:0];
    assign addr_idx = csr_addr[3:0];

    // An address register is frozen by its own lock, or by the next
    // entry's lock when that entry uses it as the TOR lower bound.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_cfg[i] = pmpcfg_t'(cfg_q[i / 4][8 * (i % 4) +: 8]);
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            addr_locked[i] = entry_cfg[i].l;
            if (i < NUM_ENTRIES - 1) begin
                if (entry_cfg[i + 1].l && (entry_cfg[i + 1].a == PMP_TOR)) begin
                    addr_locked[i] = 1'b1;
                end
            end
        end
    end

    assign old_word = is_addr ? addr_q[addr_idx] : cfg_q[cfg_idx];
    assign new_word = csr_apply_op(csr_op_e'(csr_op), old_word, csr_wdata);

    for (genvar j = 0; j < 4; j++) begin : g_cfg_leg
        pmp_cfg_legalize u_leg (
            .old_byte    (cfg_q[cfg_idx][8 * j +: 8]),
            .new_byte    (new_word[8 * j +: 8]),
            .commit_byte (cfg_commit[8 * j +: 8])
        );
    end

    assign addr_commit = addr_locked[addr_idx] ? old_word : new_word;
    assign commit_word = is_addr ? addr_commit : cfg_commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cfg_q[k] <= '0;
            end
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                addr_q[k] <= '0;
            end
            csr_rdata   <= '0;
            csr_rvalid  <= 1'b0;
            csr_illegal <= 1'b0;
            pmp_update  <= 1'b0;
        end else begin
            if (do_write) begin
                if (is_addr) begin
                    addr_q[addr_idx] <= commit_word;
                end else begin
                    cfg_q[cfg_idx] <= commit_word;
                end
            end
            pmp_update  <= do_write && (commit_word != old_word);
            csr_illegal <= illegal;
            csr_rvalid  <= illegal || (csr_re && in_range);
            // Read data is the pre-write value; illegal responses read 0.
            csr_rdata   <= (csr_re && in_range && !illegal) ? old_word : '0;
        end
    end

    assign pmpcfg0_data   = cfg_q[0];
    assign pmpcfg1_data   = cfg_q[1];
    assign pmpcfg2_data   = cfg_q[2];
    assign pmpcfg3_data   = cfg_q[3];
    assign pmpaddr0_data  = addr_q[0];
    assign pmpaddr1_data  = addr_q[1];
    assign pmpaddr2_data  = addr_q[2];
    assign pmpaddr3_data  = addr_q[3];
    assign pmpaddr4_data  = addr_q[4];
    assign pmpaddr5_data  = addr_q[5];
    assign pmpaddr6_data  = addr_q[6];
    assign pmpaddr7_data  = addr_q[7];
    assign pmpaddr8_data  = addr_q[8];
    assign pmpaddr9_data  = addr_q[9];
    assign pmpaddr10_data = addr_q[10];
    assign pmpaddr11_data = addr_q[11];
    assign pmpaddr12_data = addr_q[12];
    assign pmpaddr13_data = addr_q[13];
    assign pmpaddr14_data = addr_q[14];
    assign pmpaddr15_data = addr_q[15];

endmodule

// File: tb/tb_pmp_csr_file.sv
// tb/tb_pmp_csr_file.sv - scoreboard bench for pmp_csr_file
module tb_pmp_csr_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_we = 1'b0;
    logic        csr_re = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [1:0]  prive_mode = 2'b11;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        csr_illegal;
    logic        pmp_update;
    logic [31:0] cfg_o  [4];
    logic [31:0] addr_o [16];

    always #5 clk = ~clk;

    pmp_csr_file dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .csr_we         (csr_we),
        .csr_re         (csr_re),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .prive_mode     (prive_mode),
        .csr_rdata      (csr_rdata),
        .csr_rvalid     (csr_rvalid),
        .csr_illegal    (csr_illegal),
        .pmp_update     (pmp_update),
        .pmpcfg0_data   (cfg_o[0]),
        .pmpcfg1_data   (cfg_o[1]),
        .pmpcfg2_data   (cfg_o[2]),
        .pmpcfg3_data   (cfg_o[3]),
        .pmpaddr0_data  (addr_o[0]),
        .pmpaddr1_data  (addr_o[1]),
        .pmpaddr2_data  (addr_o[2]),
        .pmpaddr3_data  (addr_o[3]),
        .pmpaddr4_data  (addr_o[4]),
        .pmpaddr5_data  (addr_o[5]),
        .pmpaddr6_data  (addr_o[6]),
        .pmpaddr7_data  (addr_o[7]),
        .pmpaddr8_data  (addr_o[8]),
        .pmpaddr9_data  (addr_o[9]),
        .pmpaddr10_data (addr_o[10]),
        .pmpaddr11_data (addr_o[11]),
        .pmpaddr12_data (addr_o[12]),
        .pmpaddr13_data (addr_o[13]),
        .pmpaddr14_data (addr_o[14]),
        .pmpaddr15_data (addr_o[15])
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  m_cfg  [16];
    logic [31:0] m_addr [16];
    logic [32:0] exp_q [$];
    logic [32:0] exp_e;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Response monitor: one scoreboard entry per csr_rvalid pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (csr_rvalid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_rvalid", 32'(csr_rvalid), 32'h0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check_eq("rdata", csr_rdata, exp_e[31:0]);
                    check_eq("illegal", 32'(csr_illegal), 32'(exp_e[32]));
                end
            end else if (csr_illegal) begin
                check_eq("illegal_without_rvalid", 32'(csr_illegal), 32'h0);
            end
        end
    end

    function automatic logic [31:0] m_cfg_word(input int k);
        return {m_cfg[4*k+3], m_cfg[4*k+2], m_cfg[4*k+1], m_cfg[4*k]};
    endfunction

    task automatic check_buses(input string tag);
        for (int k = 0; k < 4; k++) check_eq({tag, "_cfg"}, cfg_o[k], m_cfg_word(k));
        for (int k = 0; k < 16; k++) check_eq({tag, "_addr"}, addr_o[k], m_addr[k]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        csr_we = 1'b0;
        csr_re = 1'b0;
        #1;
        for (int k = 0; k < 16; k++) begin
            m_cfg[k] = 8'h00;
            m_addr[k] = 32'h0;
        end
        exp_q.delete();
        check_eq("rst_rdata", csr_rdata, 32'h0);
        check_eq("rst_rvalid", 32'(csr_rvalid), 32'h0);
        check_eq("rst_illegal", 32'(csr_illegal), 32'h0);
        check_eq("rst_update", 32'(pmp_update), 32'h0);
        check_buses("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic access(input logic we, input logic re, input logic [1:0] op,
                          input logic [11:0] a, input logic [31:0] wd,
                          input logic [1:0] mode);
        logic        in_r, unimpl, ill, upd, locked;
        logic [31:0] old, nv, cm;
        logic [7:0]  nb;
        int          k;
        @(negedge clk);
        csr_we = we;
        csr_re = re;
        csr_op = op;
        csr_addr = a;
        csr_wdata = wd;
        prive_mode = mode;
        in_r = (a >= 12'h3A0) && (a <= 12'h3BF);
        unimpl = (a >= 12'h3A4) && (a <= 12'h3AF);
        ill = in_r && (we || re) && ((mode != 2'b11) || unimpl);
        upd = 1'b0;
        if (ill) begin
            exp_q.push_back({1'b1, 32'h0});
        end else if (in_r) begin
            if (a < 12'h3B0) begin
                k = int'(a - 12'h3A0);
                old = m_cfg_word(k);
            end else begin
                k = int'(a - 12'h3B0);
                old = m_addr[k];
            end
            if (re) exp_q.push_back({1'b0, old});
            if (we && op != 2'b00) begin
                nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
                if (a < 12'h3B0) begin
                    for (int j = 0; j < 4; j++) begin
                        nb = nv[8*j +: 8];
                        if (!m_cfg[4*k+j][7]) begin
`ifdef PMP_WARL_EN
                            nb[6:5] = 2'b00;
                            if (!nb[0]) nb[1] = 1'b0;
`endif
                            m_cfg[4*k+j] = nb;
                        end
                    end
                    cm = m_cfg_word(k);
                end else begin
                    locked = m_cfg[k][7];
                    if (k < 15) begin
                        if (m_cfg[k+1][7] && m_cfg[k+1][4:3] == 2'b01) locked = 1'b1;
                    end
                    if (!locked) m_addr[k] = nv;
                    cm = m_addr[k];
                end
                upd = (cm != old);
            end
        end
        @(posedge clk);
        #1;
        check_eq("pmp_update", 32'(pmp_update), 32'(upd));
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        csr_we = 1'b0;
        csr_re = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset and read-back of zero state
        do_reset();
        access(0, 1, 2'b00, 12'h3A0, 32'h0, 2'b11);
        access(0, 1, 2'b00, 12'h3BF, 32'h0, 2'b11);
        idle(2);
        check_buses("after_reads");

        // Write then set
        access(1, 0, 2'b01, 12'h3A0, 32'h0000_0F0D, 2'b11);
        check_eq("cfg0_write", cfg_o[0], 32'h0000_0F0D);
        access(1, 0, 2'b10, 12'h3A0, 32'h0000_0010, 2'b11);
        check_eq("cfg0_set", cfg_o[0], 32'h0000_0F1D);
        access(1, 1, 2'b11, 12'h3A0, 32'h0000_0F00, 2'b11);
        check_eq("cfg0_clear", cfg_o[0], 32'h0000_001D);
        access(1, 0, 2'b00, 12'h3A0, 32'hFFFF_FFFF, 2'b11);
        check_eq("cfg0_op_none", cfg_o[0], 32'h0000_001D);
        access(0, 1, 2'b00, 12'h300, 32'h0, 2'b11);
        idle(2);
        check_buses("rmw");

        // Reset in the middle of a pending read response
        access(0, 1, 2'b00, 12'h3A0, 32'h0, 2'b11);
        do_reset();

        // Locked entry 0 byte
        access(1, 0, 2'b01, 12'h3A0, 32'h0000_0088, 2'b11);
        access(1, 0, 2'b01, 12'h3A0, 32'hFFFF_FF00, 2'b11);
`ifdef PMP_WARL_EN
        check_eq("cfg0_lock_bytes", cfg_o[0], 32'h9F9F_9F88);
`else
        check_eq("cfg0_lock_bytes", cfg_o[0], 32'hFFFF_FF88);
`endif
        access(1, 0, 2'b01, 12'h3B0, 32'h0000_1234, 2'b11);
        check_eq("addr0_locked", addr_o[0], 32'h0);
        idle(1);
        do_reset();

        // Entry 1 locked TOR protects pmpaddr0
        access(1, 0, 2'b01, 12'h3A0, 32'h0000_8800, 2'b11);
        access(1, 0, 2'b01, 12'h3B0, 32'h0000_1234, 2'b11);
        check_eq("addr0_tor_locked", addr_o[0], 32'h0);
        access(1, 0, 2'b01, 12'h3B1, 32'h0000_5555, 2'b11);
        check_eq("addr1_locked", addr_o[1], 32'h0);
        access(1, 0, 2'b01, 12'h3B2, 32'h0000_ABCD, 2'b11);
        check_eq("addr2_write", addr_o[2], 32'h0000_ABCD);
        access(1, 0, 2'b01, 12'h3B2, 32'h0000_ABCD, 2'b11);
        access(1, 1, 2'b11, 12'h3B2, 32'h0000_000F, 2'b11);
        check_eq("addr2_clear", addr_o[2], 32'h0000_ABC0);
        access(0, 1, 2'b00, 12'h3B2, 32'h0, 2'b11);

        // Illegal accesses
        access(1, 0, 2'b01, 12'h3B5, 32'hFFFF_FFFF, 2'b00);
        check_eq("addr5_umode", addr_o[5], 32'h0);
        access(0, 1, 2'b00, 12'h3A7, 32'h0, 2'b11);
        access(1, 1, 2'b01, 12'h3AF, 32'h1234_5678, 2'b11);
        access(0, 1, 2'b00, 12'h3A0, 32'h0, 2'b01);

        // WARL handling of a config byte
        access(1, 0, 2'b01, 12'h3A1, 32'h0000_0062, 2'b11);
`ifdef PMP_WARL_EN
        check_eq("cfg1_warl", cfg_o[1], 32'h0000_0000);
`else
        check_eq("cfg1_warl", cfg_o[1], 32'h0000_0062);
`endif
        for (int i = 0; i < 6; i++) begin
            access(1, 1, 2'b01, 12'h3B8 + 12'(i), $urandom, 2'b11);
        end
        idle(3);
        check_buses("final");
        check_eq("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pmp_csr_file.md
# pmp_csr_file

Machine-mode CSR storage for the 16-entry Physical Memory Protection unit. Holds pmpcfg0–pmpcfg3 and pmpaddr0–pmpaddr15, applies read-modify-write CSR operations with lock and WARL rules, and drives the configuration and address buses consumed by the PMP address-check/priority stage. It sits between the CSR decode stage and the PMP checker.

## Interface
- NUM_ENTRIES, 16, number of PMP entries. Fixed at 16 because the checker expects exactly 16.
- clk  input  1  core clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- csr_we  input  1  write request this cycle
- csr_re  input  1  read request this cycle
- csr_op  input  2  operation: 01 write, 10 set, 11 clear; 00 is treated as no write
- csr_addr  input  12  CSR address
- csr_wdata  input  32  write operand
- prive_mode  input  2  current privilege mode; 11 is M-mode
- csr_rdata  output  32  registered read data
- csr_rvalid  output  1  read/illegal response valid, one-cycle pulse
- csr_illegal  output  1  illegal PMP access, one-cycle pulse
- pmp_update  output  1  one-cycle pulse after any write that changed stored state
- pmpcfg0_data..pmpcfg3_data  output  32 each  packed configuration bytes, entry 4k+j in bits [8j+7:8j]
- pmpaddr0_data..pmpaddr15_data  output  32 each  address registers, holding addr[33:2]

## Operation
- Address map: pmpcfg0–3 at 0x3A0–0x3A3; pmpaddr0–15 at 0x3B0–0x3BF.
- Other addresses in 0x3A0–0x3BF (0x3A4–0x3AF) are unimplemented.
- Addresses outside 0x3A0–0x3BF are ignored: no state change and no response.
- Illegal access: a PMP-range access with prive_mode != 11, or any access to an unimplemented address.
  - Drop any write.
  - csr_illegal=1, csr_rvalid=1, csr_rdata=0 in the next cycle.
- New value:
  - write: wdata
  - set: old | wdata
  - clear: old & ~wdata
- Config byte layout: {L[7], 00[6:5], A[4:3], X[2], W[1], R[0]}.
- Lock on pmpcfg words: each byte is handled independently. A byte whose stored L=1 keeps its old value; the other bytes take the new value.
- Lock on pmpaddr i: the write is dropped if entry i has L=1.
  - It is also dropped if i<15, entry i+1 has L=1, and entry i+1 has A=01 (TOR).
- A locked entry can be cleared only by reset.
- Read returns the stored value before the same-cycle write.
- pmp_update is set only when the committed value differs from the old value. A write that is fully blocked by lock does not pulse it.
- Simultaneous csr_we and csr_re to the same address: the write commits, and csr_rdata returns the old value.

## Timing
- Write is visible on the output buses at the clock edge that samples csr_we (zero-cycle latency to storage).
- Read latency is 1 cycle: csr_re in cycle N gives csr_rvalid/csr_rdata in cycle N+1. Back-to-back reads are supported every cycle.
- pmp_update is high in cycle N+1 for an effective write in cycle N.
- Reset values: all pmpcfg and pmpaddr registers 0; csr_rdata=0; csr_rvalid=0; csr_illegal=0; pmp_update=0.
- Reset asserted mid-operation clears everything immediately. A pending read response is discarded.

## Configuration
- PMP_WARL_EN defined: legalize each unlocked written config byte.
  - Bits [6:5] are forced to 0.
  - If R=0 and W=1, W is forced to 0.
  - pmp_update compares the legalized value.
- PMP_WARL_EN undefined: bytes are stored exactly as computed. Lock rules still apply.

## Structure
- Shared package pmp_pkg holds:
  - the pmpcfg packed struct {L, rsvd[1:0], A[1:0], X, W, R}
  - the A encodings OFF=00, TOR=01, NA4=10, NAPOT=11
  - the CSR base addresses 0x3A0/0x3B0
  - the csr_op encodings
- The checker imports the same pmpcfg typedef.
- One sub-module: pmp_cfg_legalize. It is combinational per byte and takes old byte, new byte → committed byte (lock + WARL). It is instantiated 4 times per cfg write path.

## Test plan
- Reset, then read 0x3A0 and 0x3BF in M-mode → csr_rvalid next cycle, rdata=0, all buses 0, pmp_update never pulsed.
- Write 0x3A0 ← 0x0000_0F0D, then set 0x3A0 with 0x0000_0010 → pmpcfg0_data=0x0000_0F1D, pmp_update pulses after each write.
- Write 0x3A0 ← 0x0000_0088 (entry0 L=1, A=01), then write 0x3A0 ← 0xFFFF_FF00 → entry0 byte stays 0x88, bytes 1–3 become 0xFF. A subsequent write to 0x3B0 is dropped.
- Write 0x3A0 ← 0x0000_8800 (entry1 locked TOR), then write 0x3B0 ← 0x1234 → pmpaddr0_data unchanged, no pmp_update. A write to 0x3B2 succeeds.
- prive_mode=00, write 0x3B5 ← 0xFFFF_FFFF → csr_illegal=1, csr_rvalid=1, rdata=0, pmpaddr5_data stays 0. Access to 0x3A7 in M-mode → csr_illegal=1.
- With PMP_WARL_EN, write 0x3A1 ← 0x0000_0062 → stored byte 0x00 (bits 6:5 cleared, W cleared since R=0). Without the macro → 0x62 stored.
